npc_predict_unit: RTL and testbench
===================================

# npc_predict_unit

Fetch-stage next-PC unit for the RV32I pipeline: owns the IF program-counter register and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it selects among branch-misprediction recovery (EX), jalr (EX), jal (ID), BTB prediction and sequential PC+4. It supersedes the purely combinational next-PC mux by registering the PC, predicting taken branches and producing the pipeline flush request.

## Interface

Parameters:
- XLEN, 32, address width.
- BTB_ENTRIES, 16, BTB depth. Must be a power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, value loaded into the PC on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  hold PC (load-use bubble).
- jal  in  1  ID stage holds a jal.
- jal_target  in  XLEN  jal destination.
- jalr  in  1  EX stage holds a jalr.
- jalr_target  in  XLEN  jalr destination.
- ex_br  in  1  EX stage holds a valid conditional branch; asserted exactly one cycle per branch.
- ex_pc  in  XLEN  PC of the EX branch.
- ex_taken  in  1  resolved branch outcome.
- ex_target  in  XLEN  resolved branch target.
- ex_pred_taken  in  1  pred_taken_f value that travelled down with this branch.
- pc_f  out  XLEN  current fetch PC (registered).
- pred_taken_f  out  1  BTB predicts pc_f as a taken branch (combinational from pc_f).
- mispredict  out  1  branch misprediction in EX; flush IF/ID and ID/EX (combinational).

## Operation

- BTB entry: valid (1), tag (XLEN-IDX_W-2 bits = pc[XLEN-1:IDX_W+2]), target (XLEN), ctr (2). Index = pc[IDX_W+1:2].
- Lookup on pc_f: hit = valid & tag match. pred_taken_f = hit & ctr[1].
- mispredict = ex_br & (ex_taken != ex_pred_taken).
- Next-PC priority, highest first:
  1. rst → RESET_PC.
  2. mispredict & ex_taken → ex_target.
  3. mispredict & !ex_taken → ex_pc + 4.
  4. jalr → jalr_target.
  5. jal → jal_target.
  6. stall_f → hold pc_f.
  7. pred_taken_f → BTB target.
  8. otherwise pc_f + 4.
- Items 2–5 update the PC even when stall_f is high.
- PC+4 arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0. pc[1:0] is never checked.
- BTB update on ex_br (independent of stall_f), indexed by ex_pc:
  - Hit, taken: ctr saturating increment (max 3); target ← ex_target.
  - Hit, not taken: ctr saturating decrement (min 0). The entry stays valid.
  - Miss, taken: allocate, overwriting any alias: valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update contents. The write lands at the clock edge.
- Reset clears every valid bit. Target and ctr contents are don't-care after reset.

## Timing

- Reset values: pc_f = RESET_PC. pred_taken_f = 0 (all entries invalid). mispredict follows its inputs.
- Reset asserted mid-operation: PC and valid bits clear at the next edge. rst overrides every other input, including a concurrent BTB update.
- Redirect latency is 1 cycle: the selected next PC appears on pc_f after the next rising edge.
- Prediction adds no fetch bubble: a predicted-taken pc_f yields the target as pc_f on the next cycle.
- BTB write to prediction-visible latency is 1 cycle.
- mispredict is combinational within the ex_br cycle. The core flushes younger stages in that same cycle.

## Configuration

- NPC_BTB_EN defined: the BTB and prediction logic above are built.
- NPC_BTB_EN undefined:
  - No BTB storage is built, and pred_taken_f is tied 0.
  - Priority item 7 is removed (static not-taken).
  - mispredict reduces to ex_br & ex_taken, given ex_pred_taken = 0.
  - All other behaviour is unchanged.

## Test plan

- Reset: hold rst 2 cycles with RESET_PC=32'h100 → pc_f=32'h100 and pred_taken_f=0. After release, with no events, pc_f steps 32'h104, 32'h108.
- Branch learning:
  - Branch at 32'h20, target 32'h80, taken with ex_pred_taken=0 → mispredict=1, pc_f=32'h80 next cycle, entry allocated with ctr=2.
  - Refetch of 32'h20 → pred_taken_f=1, then pc_f=32'h80.
- Counter hysteresis:
  - Drive the same branch taken twice (ctr=3), then not taken once → still predicted taken.
  - A second not-taken → ctr=1 and pred_taken_f=0 on the next fetch of 32'h20.
- Priority: in one cycle assert mispredict (taken, target 32'h400), jalr (32'h500), jal (32'h600) and stall_f → pc_f=32'h400. Drop mispredict → 32'h500.
- Stall and wrap:
  - stall_f high for 3 cycles → pc_f constant.
  - pc_f=32'hFFFF_FFFC with no events → pc_f=32'h0.
- Aliasing (BTB_ENTRIES=16): a taken branch at 32'h40 allocates the index. A taken branch at 32'h80 (same index) then evicts it → a refetch of 32'h40 gives pred_taken_f=0.

Source files
------------

// File: rtl/npc_predict_unit_if.sv
// Fetch next-PC bus between the core pipeline (master) and npc_predict_unit (slave).
interface npc_predict_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_f;
    logic            jal;
    logic [XLEN-1:0] jal_target;
    logic            jalr;
    logic [XLEN-1:0] jalr_target;
    logic            ex_br;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic            mispredict;

    modport master (
        output stall_f, jal, jal_target, jalr, jalr_target,
               ex_br, ex_pc, ex_taken, ex_target, ex_pred_taken,
        input  pc_f, pred_taken_f, mispredict
    );

    modport slave (
        input  stall_f, jal, jal_target, jalr, jalr_target,
               ex_br, ex_pc, ex_taken, ex_target, ex_pred_taken,
        output pc_f, pred_taken_f, mispredict
    );
endinterface

// File: rtl/npc_predict_unit.sv
// Fetch-stage next-PC unit: registered IF PC, optional direct-mapped BTB
// with 2-bit saturating counters, and branch misprediction flush request.
// Optional feature macro: NPC_BTB_EN (defined = BTB and prediction built;
// undefined = static not-taken, pred_taken_f tied low).
module npc_predict_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst,
    npc_predict_unit_if.slave   npc
);

    if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_cfg
        $error("npc_predict_unit: BTB_ENTRIES must be a power of two >= 2");
    end

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misp;
    logic            pred;

    assign misp = npc.ex_br & (npc.ex_taken != npc.ex_pred_taken);

    assign npc.pc_f         = pc_q;
    assign npc.pred_taken_f = pred;
    assign npc.mispredict   = misp;

`ifdef NPC_BTB_EN
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_d [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [1:0]             ctr_d [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [XLEN-1:0]  lk_tgt;

    // Lookup on the current fetch PC; sees pre-update contents.
    always_comb begin
        lk_idx = pc_q[IDX_W+1:2];
        lk_tag = pc_q[XLEN-1:IDX_W+2];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_tgt = tgt_q[lk_idx];
        pred   = lk_hit & ctr_q[lk_idx][1];
    end

    // Train on the resolved EX branch: counter update on hit, allocate on taken miss.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        up_idx  = npc.ex_pc[IDX_W+1:2];
        up_tag  = npc.ex_pc[XLEN-1:IDX_W+2];
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (npc.ex_br) begin
            if (up_hit) begin
                if (npc.ex_taken) begin
                    if (ctr_q[up_idx] != 2'd3) ctr_d[up_idx] = 2'(ctr_q[up_idx] + 2'd1);
                    tgt_d[up_idx] = npc.ex_target;
                end else begin
                    if (ctr_q[up_idx] != 2'd0) ctr_d[up_idx] = 2'(ctr_q[up_idx] - 2'd1);
                end
            end else if (npc.ex_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = npc.ex_target;
                ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // BTB storage; only valid bits are reset, reset also blocks a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end
`else
    assign pred = 1'b0;
`endif

    // Next-PC selection; redirects beat stall, stall beats prediction and PC+4.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (misp && npc.ex_taken) begin
            pc_d = npc.ex_target;
        end else if (misp) begin
            pc_d = npc.ex_pc + XLEN'(4);
        end else if (npc.jalr) begin
            pc_d = npc.jalr_target;
        end else if (npc.jal) begin
            pc_d = npc.jal_target;
        end else if (npc.stall_f) begin
            pc_d = pc_q;
`ifdef NPC_BTB_EN
        end else if (pred) begin
            pc_d = lk_tgt;
`endif
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Self-checking bench for npc_predict_unit (RESET_PC=32'h100, BTB_ENTRIES=16).
module tb_npc_predict_unit;

`ifdef NPC_BTB_EN
    localparam logic BTB = 1'b1;
`else
    localparam logic BTB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npc_predict_unit_if #(.XLEN(32)) bus ();

    npc_predict_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .npc (bus)
    );

    typedef struct {
        logic        stall;
        logic        jal;
        logic [31:0] jal_t;
        logic        jalr;
        logic [31:0] jalr_t;
        logic        br;
        logic [31:0] br_pc;
        logic        tk;
        logic [31:0] tgt;
        logic        pt;
        logic        e_misp;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [13];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        bus.stall_f = 1'b0; bus.jal = 1'b0; bus.jal_target = '0;
        bus.jalr = 1'b0; bus.jalr_target = '0; bus.ex_br = 1'b0;
        bus.ex_pc = '0; bus.ex_taken = 1'b0; bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0;
    endtask

    task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
        bus.ex_br = 1'b1; bus.ex_pc = pc; bus.ex_taken = tk;
        bus.ex_target = tgt; bus.ex_pred_taken = pt;
    endtask

    task automatic jal_to(input logic [31:0] t);
        bus.jal = 1'b1; bus.jal_target = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          stall jal jal_t         jalr jalr_t     br  br_pc      tk  tgt        pt  misp pc
        vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h10C};
        vt[1]  = '{1'b1, 1'b1, 32'h600,      1'b1, 32'h500, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400};
        vt[2]  = '{1'b1, 1'b1, 32'h600,      1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h500};
        vt[3]  = '{1'b1, 1'b1, 32'h600,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h600};
        vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h600};
        vt[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h600};
        vt[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h600};
        vt[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h700, 1'b0, 32'h900, 1'b1, 1'b1, 32'h704};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h704, 1'b1, 32'h900, 1'b1, 1'b0, 32'h708};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h704, 1'b0, 32'h900, 1'b0, 1'b0, 32'h70C};
        vt[10] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'hFFFFFFFC};
        vt[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h4};

        // Reset held two cycles, then free-running PC+4.
        rst = 1'b1;
        idle();
        step();
        chk("reset_pc", bus.pc_f, 32'h100);
        chk("reset_pred", 32'(bus.pred_taken_f), 32'h0);
        step();
        chk("reset_pc_hold", bus.pc_f, 32'h100);
        rst = 1'b0;
        step();
        chk("seq_104", bus.pc_f, 32'h104);
        step();
        chk("seq_108", bus.pc_f, 32'h108);

        // Priority, stall, mispredict recovery and wrap vectors.
        for (int i = 0; i < 13; i++) begin
            bus.stall_f = vt[i].stall; bus.jal = vt[i].jal; bus.jal_target = vt[i].jal_t;
            bus.jalr = vt[i].jalr; bus.jalr_target = vt[i].jalr_t; bus.ex_br = vt[i].br;
            bus.ex_pc = vt[i].br_pc; bus.ex_taken = vt[i].tk; bus.ex_target = vt[i].tgt;
            bus.ex_pred_taken = vt[i].pt;
            #1;
            chk($sformatf("vec%0d_misp", i), 32'(bus.mispredict), 32'(vt[i].e_misp));
            step();
            chk($sformatf("vec%0d_pc", i), bus.pc_f, vt[i].e_pc);
        end
        idle();

        // Branch learning at 32'h20 -> 32'h80.
        jal_to(32'h20); step(); idle();
        chk("learn_pc20", bus.pc_f, 32'h20);
        #1 chk("learn_pred_cold", 32'(bus.pred_taken_f), 32'h0);
        br(32'h20, 1'b1, 32'h80, 1'b0);
        #1 chk("learn_misp", 32'(bus.mispredict), 32'h1);
        step(); idle();
        chk("learn_redirect", bus.pc_f, 32'h80);
        jal_to(32'h20); step(); idle();
        #1 chk("learn_pred_hot", 32'(bus.pred_taken_f), 32'(BTB));
        step();
        chk("learn_follow", bus.pc_f, BTB ? 32'h80 : 32'h24);

        // Counter hysteresis: two taken, then not-taken twice.
        for (int k = 0; k < 2; k++) begin
            br(32'h20, 1'b1, 32'h80, 1'b1); jal_to(32'h200);
            #1 chk($sformatf("hyst_tk%0d_misp", k), 32'(bus.mispredict), 32'h0);
            step(); idle();
        end
        br(32'h20, 1'b0, 32'h80, 1'b1);
        #1 chk("hyst_nt1_misp", 32'(bus.mispredict), 32'h1);
        step(); idle();
        chk("hyst_nt1_pc", bus.pc_f, 32'h24);
        jal_to(32'h20); step(); idle();
        #1 chk("hyst_nt1_pred", 32'(bus.pred_taken_f), 32'(BTB));
        br(32'h20, 1'b0, 32'h80, 1'b1); step(); idle();
        chk("hyst_nt2_pc", bus.pc_f, 32'h24);
        jal_to(32'h20); step(); idle();
        #1 chk("hyst_nt2_pred", 32'(bus.pred_taken_f), 32'h0);
        step();
        chk("hyst_nt2_seq", bus.pc_f, 32'h24);

        // Stall for three cycles.
        bus.stall_f = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d", k), bus.pc_f, 32'h24);
        end
        idle();

        // Aliasing: 32'h40 and 32'h80 share index 0.
        br(32'h40, 1'b1, 32'h140, 1'b0); step(); idle();
        chk("alias_redirect", bus.pc_f, 32'h140);
        jal_to(32'h40); step(); idle();
        #1 chk("alias_pred40", 32'(bus.pred_taken_f), 32'(BTB));
        step();
        chk("alias_follow40", bus.pc_f, BTB ? 32'h140 : 32'h44);
        br(32'h80, 1'b1, 32'h180, 1'b1); jal_to(32'h40); step(); idle();
        chk("alias_jal40", bus.pc_f, 32'h40);
        #1 chk("alias_evicted", 32'(bus.pred_taken_f), 32'h0);
        step();
        chk("alias_seq44", bus.pc_f, 32'h44);
        jal_to(32'h80); step(); idle();
        #1 chk("alias_pred80", 32'(bus.pred_taken_f), 32'(BTB));

        // Mid-run reset overrides jal and a concurrent BTB allocation.
        rst = 1'b1;
        br(32'h40, 1'b1, 32'h140, 1'b0); jal_to(32'h300);
        step(); idle(); rst = 1'b0;
        chk("rst_mid_pc", bus.pc_f, 32'h100);
        jal_to(32'h80); step(); idle();
        #1 chk("rst_mid_clr80", 32'(bus.pred_taken_f), 32'h0);
        jal_to(32'h40); step(); idle();
        #1 chk("rst_mid_noalloc40", 32'(bus.pred_taken_f), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
